multi_lane_deserializer: RTL and testbench
==========================================

# multi_lane_deserializer

Parametrised receive-side deserializer for the USB4 logical layer. It converts LANES serial receive bit streams into WIDTH-bit parallel words, with word length selected by gen_speed. It adds a per-word valid strobe, bit-slip word alignment and a clean restart on speed change. It sits between the lane serial inputs and the per-lane descramblers/decoders, and drives their reset and enable.

## Interface
Parameters:
- WIDTH, 132, GEN3 word length in bits; GEN2 word length is WIDTH/2 and GEN4 word length is fixed at 8. WIDTH must be even and at least 16.
- LANES, 2, number of serial lanes, at least 1.

Ports:
- clk  in  1  single clock; one serial bit per lane is sampled per rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable_deser  in  1  deserializer enable; low acts as a synchronous clear.
- gen_speed  in  2  speed select: 00 GEN4 (N=8, MSB-first), 01 GEN3 (N=WIDTH, LSB-first), 10 GEN2 (N=WIDTH/2, LSB-first), 11 same as GEN4.
- rx_ser  in  LANES  serial bit of lane i on bit i.
- bit_slip  in  1  when high on an enabled edge, the word boundary moves one bit later.
- rx_parallel  out  LANES*WIDTH  lane i word on [i*WIDTH +: WIDTH].
- rx_valid  out  1  one-cycle pulse marking a newly loaded rx_parallel.
- descr_rst  out  1  descrambler reset pulse, one cycle before a word's final bit.
- enable_dec  out  1  decoder enable, held high once the first word is delivered.

## Operation
- Per lane there is a WIDTH-bit shift register; one shared bit counter `count` runs 0..N-1. There is also a registered copy of gen_speed, gen_q.
- **Reset (rst low) or enable_deser low:** shift registers, count, gen_q, rx_parallel, rx_valid and enable_dec all go to 0.
- **Speed change:** on an enabled edge where gen_speed != gen_q:
  - gen_q is loaded from gen_speed.
  - Shift registers and count are cleared, and enable_dec drops to 0.
  - No bit is sampled on that edge and no word is emitted.
- **Normal enabled edge:** one bit is shifted in per lane.
  - GEN4: shift left, new bit enters bit 0.
  - GEN2/GEN3: shift right, new bit enters bit N-1.
  - If bit_slip is high, count holds.
  - Otherwise, if count == N-1, count goes to 0. Else count increments.
- **Word capture:** happens on an edge where count == N-1 and bit_slip is low.
  - rx_parallel receives each lane's word including the bit sampled on that edge.
  - Bits N..WIDTH-1 of each lane are zero.
  - rx_valid is set to 1 on that edge; on all other edges it is 0.
  - enable_dec is set to 1 and stays 1 until reset, disable or speed change.
- **Bit order, for word bits b0 (first sampled) .. b(N-1):**
  - GEN4: b0 lands in lane bit 7, b7 in lane bit 0.
  - GEN2/GEN3: b0 lands in lane bit 0, b(N-1) in lane bit N-1.
- **rx_parallel hold:** rx_parallel holds its value between captures.
- **descr_rst:** combinational, equal to enable_deser & rst & (count == N-2) & (gen_speed == gen_q).
- **Counter width:** $clog2(WIDTH) bits. N-1 and N-2 are computed at that width.

## Timing
- The first enabled edge after rst deassertion (or after enable rises, or after a speed change) samples b0 with count=0.
- The first word is captured on the Nth enabled edge, i.e. on b(N-1). rx_valid is high in the following cycle.
- Latency from last bit sampled to word visible: 1 cycle.
- Word period is N edges; each bit_slip pulse adds 1 edge.
- bit_slip on the capture edge (count == N-1) defers capture by one edge. The deferred word contains b1..bN, shifted by one bit.
- Consecutive bit_slip cycles each add one edge of delay.
- rst asserted mid-word takes effect immediately; the partial word is lost and rx_valid never pulses for it.
- enable_deser falling mid-word clears on the next edge. A capture scheduled on that edge does not occur.
- A speed change takes priority over bit_slip and capture on the same edge.
- gen_speed = 11 behaves exactly as 00, and a change between 00 and 11 still counts as a speed change.

## Test plan
- **GEN4, LANES=2:**
  - Stimulus: after reset, enable and drive lane0 bits 1,0,1,1,0,0,1,0 and lane1 their inverse.
  - Response: after the 8th edge, rx_valid=1, lane0 word=0x0B2, lane1 word=0x04D. descr_rst high while count=6; enable_dec=1 from that cycle.
- **GEN3:**
  - Stimulus: drive a 132-bit word, LSB first.
  - Response: rx_parallel lane0 equals the word on the edge after bit 131; rx_valid pulses once every 132 cycles.
- **GEN2:**
  - Stimulus: drive 66-bit 0x2_AAAA_AAAA_AAAA_AAAA, LSB first.
  - Response: lane word equals that value, bits 131..66 are zero, rx_valid pulses every 66 cycles.
- **bit_slip in GEN4:**
  - Stimulus: repeated 0xA5 stream with one bit_slip pulse.
  - Response: the next word is 0x4B (boundary shifted by one bit), and that rx_valid gap is 9 cycles instead of 8.
- **Speed change / disable:**
  - Stimulus: change gen_speed from GEN3 to GEN4 at count=40.
  - Response: no rx_valid; enable_dec goes to 0; first GEN4 word 8 edges later. Dropping enable_deser clears all outputs to 0 on the next edge.
- **Parametrisation:**
  - Stimulus: WIDTH=132, LANES=4, independent patterns per lane in GEN4.
  - Response: each lane's word appears in its own slice [i*132 +: 132] with the correct value; rst low mid-word gives all outputs 0 immediately.

Source files
------------

// File: rtl/multi_lane_deserializer.sv
// -----------------------------------------------------------------------------
// multi_lane_deserializer
//
// Receive-side deserializer for the USB4 logical layer. Each clock edge samples
// one serial bit per lane into that lane's shift register. A complete word is
// copied to rx_parallel with a one-cycle rx_valid strobe. The word length
// depends on the selected speed:
//   GEN4 (00/11) : 8 bits, MSB-first (first bit received ends up in bit 7)
//   GEN3 (01)    : WIDTH bits, LSB-first
//   GEN2 (10)    : WIDTH/2 bits, LSB-first
// bit_slip holds the bit counter for one edge, which moves the word boundary
// one bit later. A change of gen_speed restarts deserialization cleanly.
//
// Ports
//   clk           in   sample clock, one bit per lane per rising edge
//   rst           in   asynchronous active-low reset
//   enable_deser  in   deserializer enable; low clears synchronously
//   gen_speed     in   speed select (see table above)
//   rx_ser        in   serial bit of lane i on bit i
//   bit_slip      in   delay the word boundary by one bit
//   rx_parallel   out  lane i word on [i*WIDTH +: WIDTH], held between words
//   rx_valid      out  one-cycle pulse when rx_parallel is reloaded
//   descr_rst     out  descrambler reset, high one edge before a word's last bit
//   enable_dec    out  decoder enable, high once the first word is delivered
// -----------------------------------------------------------------------------
module multi_lane_deserializer #(
    parameter int WIDTH = 132,
    parameter int LANES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_deser,
    input  logic [1:0]             gen_speed,
    input  logic [LANES-1:0]       rx_ser,
    input  logic                   bit_slip,
    output logic [LANES*WIDTH-1:0] rx_parallel,
    output logic                   rx_valid,
    output logic                   descr_rst,
    output logic                   enable_dec
);

    localparam int         CW   = $clog2(WIDTH);
    localparam logic [1:0] GEN3 = 2'b01;
    localparam logic [1:0] GEN2 = 2'b10;

    logic [WIDTH-1:0]       sr_q [LANES];
    logic [WIDTH-1:0]       sr_d [LANES];
    logic [CW-1:0]          count_q, count_d;
    logic [1:0]             gen_q, gen_d;
    logic [LANES*WIDTH-1:0] par_q, par_d;
    logic                   valid_q, valid_d;
    logic                   dec_q, dec_d;

    logic [CW-1:0]          last_cnt;
    logic [CW-1:0]          pen_cnt;
    logic                   is_gen4;
    logic                   capture;

    // Terminal count (N-1) and the count one before it (N-2) for the
    // speed that is currently running.
    always_comb begin
        last_cnt = CW'(7);
        pen_cnt  = CW'(6);
        case (gen_q)
            GEN3: begin
                last_cnt = CW'(WIDTH - 1);
                pen_cnt  = CW'(WIDTH - 2);
            end
            GEN2: begin
                last_cnt = CW'(WIDTH/2 - 1);
                pen_cnt  = CW'(WIDTH/2 - 2);
            end
            default: begin
                last_cnt = CW'(7);
                pen_cnt  = CW'(6);
            end
        endcase
    end

    // 00 and 11 both select GEN4.
    assign is_gen4 = (gen_q[0] == gen_q[1]);
    assign capture = (count_q == last_cnt) && !bit_slip;

    always_comb begin
        sr_d    = sr_q;
        count_d = count_q;
        gen_d   = gen_q;
        par_d   = par_q;
        valid_d = 1'b0;
        dec_d   = dec_q;

        if (!enable_deser) begin
            sr_d    = '{default: '0};
            count_d = '0;
            gen_d   = 2'b00;
            par_d   = '0;
            dec_d   = 1'b0;
        end else if (gen_speed != gen_q) begin
            // Restart on speed change: nothing is sampled on this edge.
            sr_d    = '{default: '0};
            count_d = '0;
            gen_d   = gen_speed;
            dec_d   = 1'b0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                case (gen_q)
                    GEN3:    sr_d[l] = {rx_ser[l], sr_q[l][WIDTH-1:1]};
                    // Upper half stays zero so the captured word needs no mask.
                    GEN2:    sr_d[l] = {{(WIDTH/2){1'b0}}, rx_ser[l], sr_q[l][WIDTH/2-1:1]};
                    default: sr_d[l] = {sr_q[l][WIDTH-2:0], rx_ser[l]};
                endcase
            end

            if (!bit_slip) begin
                count_d = (count_q == last_cnt) ? '0 : count_q + CW'(1);
            end

            if (capture) begin
                valid_d = 1'b1;
                dec_d   = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    // GEN4 shifts left forever; only the newest 8 bits are the word.
                    par_d[l*WIDTH +: WIDTH] = is_gen4 ? {{(WIDTH-8){1'b0}}, sr_d[l][7:0]}
                                                      : sr_d[l];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q    <= '{default: '0};
            count_q <= '0;
            gen_q   <= 2'b00;
            par_q   <= '0;
            valid_q <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            count_q <= count_d;
            gen_q   <= gen_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign rx_parallel = par_q;
    assign rx_valid    = valid_q;
    assign enable_dec  = dec_q;
    assign descr_rst   = enable_deser & rst & (count_q == pen_cnt) & (gen_speed == gen_q);

endmodule

// File: tb/tb_multi_lane_deserializer.sv
module tb_multi_lane_deserializer;

    localparam int WIDTH = 132;
    localparam int LANES = 4;
    localparam int PW    = WIDTH * LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable_deser;
    logic [1:0]       gen_speed;
    logic [LANES-1:0] rx_ser;
    logic             bit_slip;
    logic [PW-1:0]    rx_parallel;
    logic             rx_valid;
    logic             descr_rst;
    logic             enable_dec;

    multi_lane_deserializer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_deser (enable_deser),
        .gen_speed    (gen_speed),
        .rx_ser       (rx_ser),
        .bit_slip     (bit_slip),
        .rx_parallel  (rx_parallel),
        .rx_valid     (rx_valid),
        .descr_rst    (descr_rst),
        .enable_dec   (enable_dec)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits received since the last restart, per lane.
    bit            hist [LANES][$];
    int            m_count;
    logic [1:0]    m_gen;
    logic [PW-1:0] m_par;
    logic          m_valid;
    logic          m_dec;

    task automatic check_val(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_len(input logic [1:0] g);
        if (g == 2'b01) return WIDTH;
        if (g == 2'b10) return WIDTH / 2;
        return 8;
    endfunction

    task automatic model_clear();
        m_count = 0;
        m_gen   = 2'b00;
        for (int l = 0; l < LANES; l++) hist[l].delete();
        m_par   = '0;
        m_valid = 1'b0;
        m_dec   = 1'b0;
    endtask

    // The word is the last N bits received; GEN4 puts the first of them in
    // the MSB, the other speeds put it in bit 0.
    task automatic model_capture(input int n);
        logic [WIDTH-1:0] w;
        int base;
        for (int l = 0; l < LANES; l++) begin
            w    = '0;
            base = hist[l].size() - n;
            for (int k = 0; k < n; k++) begin
                if (word_len(m_gen) == 8) w[n-1-k] = hist[l][base+k];
                else                      w[k]     = hist[l][base+k];
            end
            m_par[l*WIDTH +: WIDTH] = w;
        end
    endtask

    task automatic model_edge();
        int n;
        if (!rst || !enable_deser) begin
            model_clear();
        end else if (gen_speed != m_gen) begin
            m_gen   = gen_speed;
            m_count = 0;
            for (int l = 0; l < LANES; l++) hist[l].delete();
            m_valid = 1'b0;
            m_dec   = 1'b0;
        end else begin
            n = word_len(m_gen);
            for (int l = 0; l < LANES; l++) begin
                hist[l].push_back(rx_ser[l]);
                if (hist[l].size() > WIDTH) void'(hist[l].pop_front());
            end
            if (m_count == n - 1 && !bit_slip) begin
                model_capture(n);
                m_valid = 1'b1;
                m_dec   = 1'b1;
                m_count = 0;
            end else begin
                m_valid = 1'b0;
                if (!bit_slip) m_count++;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_descr;
        exp_descr = enable_deser && rst && (m_count == word_len(m_gen) - 2) && (gen_speed == m_gen);
        check_val("rx_parallel", rx_parallel, m_par);
        check_val("rx_valid",    PW'(rx_valid),   PW'(m_valid));
        check_val("enable_dec",  PW'(enable_dec), PW'(m_dec));
        check_val("descr_rst",   PW'(descr_rst),  PW'(exp_descr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_random(input int cycles, input int slip_pct);
        for (int c = 0; c < cycles; c++) begin
            rx_ser   = LANES'($urandom);
            bit_slip = ($urandom_range(0, 99) < slip_pct);
            step();
        end
        bit_slip = 1'b0;
    endtask

    logic [7:0]   g4_l0;
    logic [7:0]   a5;
    logic [131:0] w3;
    logic [65:0]  w2;

    initial begin
        rst          = 1'b1;
        enable_deser = 1'b0;
        gen_speed    = 2'b00;
        rx_ser       = '0;
        bit_slip     = 1'b0;
        #2 rst = 1'b0;
        model_clear();
        #1;
        check_outputs();
        rst          = 1'b1;
        enable_deser = 1'b1;

        // GEN4: lane0 1,0,1,1,0,0,1,0, lane1 inverse, other lanes random.
        g4_l0 = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            rx_ser[0] = g4_l0[7-i];
            rx_ser[1] = ~g4_l0[7-i];
            rx_ser[2] = 1'($urandom);
            rx_ser[3] = 1'($urandom);
            step();
            if (i == 5) check_val("gen4_descr_cnt6", PW'(descr_rst), PW'(1));
        end
        check_val("gen4_valid", PW'(rx_valid), PW'(1));
        check_val("gen4_lane0", PW'(rx_parallel[0 +: WIDTH]), PW'(8'hB2));
        check_val("gen4_lane1", PW'(rx_parallel[WIDTH +: WIDTH]), PW'(8'h4D));
        check_val("gen4_dec",   PW'(enable_dec), PW'(1));

        // bit_slip on the capture edge of the second 0xA5 word.
        a5 = 8'hA5;
        for (int i = 0; i < 17; i++) begin
            rx_ser   = {LANES{a5[7 - (i % 8)]}};
            bit_slip = (i == 15);
            step();
            if (i == 7)  check_val("slip_first_word", PW'(rx_parallel[0 +: WIDTH]), PW'(8'hA5));
            if (i == 15) check_val("slip_deferred",   PW'(rx_valid), PW'(0));
        end
        bit_slip = 1'b0;
        check_val("slip_word",  PW'(rx_parallel[0 +: WIDTH]), PW'(8'h4B));
        check_val("slip_valid", PW'(rx_valid), PW'(1));

        // GEN3 word, LSB first.
        gen_speed = 2'b01;
        step();
        w3 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 132; i++) begin
            rx_ser    = LANES'($urandom);
            rx_ser[0] = w3[i];
            step();
        end
        check_val("gen3_word",  PW'(rx_parallel[0 +: WIDTH]), PW'(w3));
        check_val("gen3_valid", PW'(rx_valid), PW'(1));

        // Speed change GEN3 -> GEN4 at count 40.
        run_random(40, 0);
        gen_speed = 2'b00;
        step();
        check_val("chg_no_valid", PW'(rx_valid),   PW'(0));
        check_val("chg_dec_drop", PW'(enable_dec), PW'(0));
        run_random(8, 0);
        check_val("chg_gen4_valid", PW'(rx_valid), PW'(1));

        // GEN4 alias 11 still restarts.
        gen_speed = 2'b11;
        run_random(12, 0);

        // GEN2 word.
        gen_speed = 2'b10;
        step();
        w2 = 66'h2_AAAA_AAAA_AAAA_AAAA;
        for (int i = 0; i < 66; i++) begin
            rx_ser    = LANES'($urandom);
            rx_ser[0] = w2[i];
            step();
        end
        check_val("gen2_word",  PW'(rx_parallel[0 +: WIDTH]), PW'(w2));
        check_val("gen2_valid", PW'(rx_valid), PW'(1));

        // Disable mid-word.
        run_random(10, 0);
        enable_deser = 1'b0;
        step();
        check_val("dis_par",   rx_parallel,      '0);
        check_val("dis_valid", PW'(rx_valid),    PW'(0));
        check_val("dis_dec",   PW'(enable_dec),  PW'(0));
        enable_deser = 1'b1;
        gen_speed    = 2'b00;
        run_random(30, 0);

        // Asynchronous reset mid-word.
        run_random(3, 0);
        rst = 1'b0;
        #1;
        check_val("rst_par",   rx_parallel,     '0);
        check_val("rst_valid", PW'(rx_valid),   PW'(0));
        check_val("rst_dec",   PW'(enable_dec), PW'(0));
        check_val("rst_descr", PW'(descr_rst),  PW'(0));
        model_clear();
        step();
        rst = 1'b1;

        // Randomized phases: speed changes, disables, bit slips.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) gen_speed = 2'($urandom);
            enable_deser = ($urandom_range(0, 9) != 0);
            run_random($urandom_range(10, 200), 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
